// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU operand sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } seq_state_e;

  localparam int ALU_WIDTH    = 6;
  localparam int DEBOUNCE_DEF = 16;

  // Signed overflow of a WIDTH-bit add/subtract, judged from the operand/result sign bits.
  function automatic logic alu_ovf(input logic a_msb, input logic b_msb,
                                   input logic y_msb, input logic sub);
    return (sub ? (a_msb != b_msb) : (a_msb == b_msb)) && (y_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_btn_conditioner.sv
// Load-button conditioner: 2-flop synchronizer, optional debouncer, rising-edge detector.
// Debouncer is built only when ALU_SEQ_DEBOUNCE_EN is defined.
module btn_conditioner
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic [1:0] sync;
  logic       lvl;
  logic       lvl_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], btn};
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          db;
  logic [CW-1:0] db_cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (sync[1] == db) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      db     <= ~db;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  assign lvl = db;
`else
  assign lvl = sync[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  assign press = lvl & ~lvl_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A, then B/SEL from switches, drives the external adder and latches Y/Cout + flags.
// Define ALU_SEQ_DEBOUNCE_EN to debounce the load button.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = ALU_WIDTH,
  parameter int EXEC_CYCLES     = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             sw_sel,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_sel,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic             result_valid,
  output logic [1:0]       state_o
);

  localparam int EW = $clog2(EXEC_CYCLES + 1);

  if (EXEC_CYCLES < 1) begin : g_bad_exec
    $error("alu_op_sequencer: EXEC_CYCLES must be >= 1");
  end

  seq_state_e    state, state_nx;
  logic [EW-1:0] cnt;
  logic          press;
  logic          ld_a, ld_b, cap, clr;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_load),
    .press (press)
  );

  always_comb begin
    state_nx = state;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    cap      = 1'b0;
    clr      = 1'b0;
    case (state)
      LOAD_A: if (press) begin ld_a = 1'b1; state_nx = LOAD_B; end
      LOAD_B: if (press) begin ld_b = 1'b1; state_nx = EXEC;   end
      EXEC:   if (cnt == '0) begin cap = 1'b1; state_nx = SHOW; end
      SHOW:   if (press) begin clr = 1'b1; state_nx = LOAD_A; end
      default: state_nx = LOAD_A;
    endcase
  end

  // Counter starts at EXEC_CYCLES so the first EXEC cycle covers operand propagation
  // into the adder, followed by EXEC_CYCLES settle cycles before capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      cnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_sel       <= 1'b0;
      result       <= '0;
      flag_c       <= 1'b0;
      flag_v       <= 1'b0;
      flag_z       <= 1'b0;
      flag_n       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (ld_a) op_a <= sw_data;
      if (ld_b) begin
        op_b   <= sw_data;
        op_sel <= sw_sel;
        cnt    <= EW'(EXEC_CYCLES);
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - EW'(1);
      end
      if (cap) begin
        result       <= alu_y;
        flag_c       <= alu_cout;
        flag_v       <= alu_ovf(op_a[WIDTH-1], op_b[WIDTH-1], alu_y[WIDTH-1], op_sel);
        flag_z       <= ~|alu_y;
        flag_n       <= alu_y[WIDTH-1];
        result_valid <= 1'b1;
      end
      if (clr) result_valid <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with an integer-arithmetic reference model.
// Define ALU_SEQ_DEBOUNCE_EN to exercise the debounced build.
module tb_alu_op_sequencer;

  localparam int W  = 6;
  localparam int DB = 16;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int EXN      = 60;
  localparam int HOLD_MIN = DB + 4;
  localparam int GAP      = DB + 4;
  localparam int XP_START = 24;
`else
  localparam int EXN      = 8;
  localparam int HOLD_MIN = 3;
  localparam int GAP      = 3;
  localparam int XP_START = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_load = 1'b0;
  logic [W-1:0] sw_data = '0;
  logic         sw_sel = 1'b0;
  logic [W-1:0] op_a, op_b, alu_y, result;
  logic         op_sel, alu_cout, flag_c, flag_v, flag_z, flag_n, result_valid;
  logic [1:0]   state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External Sum_Rest adder: subtract is A + ~B + 1.
  assign {alu_cout, alu_y} = op_sel ? ({1'b0, op_a} + {1'b0, ~op_b} + 7'd1)
                                    : ({1'b0, op_a} + {1'b0, op_b});

  alu_op_sequencer #(.WIDTH(W), .EXEC_CYCLES(EXN), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_load(btn_load), .sw_data(sw_data), .sw_sel(sw_sel),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .alu_y(alu_y), .alu_cout(alu_cout),
    .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .result_valid(result_valid), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hold);
    @(negedge clk);
    btn_load = 1'b1;
    repeat (hold) @(negedge clk);
    btn_load = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int budget);
    int i = 0;
    while (state_o !== exp && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(state_o), 32'(exp));
  endtask

  // Reference: signed/unsigned integer arithmetic on the 6-bit operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                       output logic [W-1:0] y, output logic c, output logic v,
                       output logic z, output logic n);
    int sa, sb, r, ua, ub;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - 64 : ua;
    sb = b[W-1] ? ub - 64 : ub;
    r  = sel ? sa - sb : sa + sb;
    v  = (r > 31) || (r < -32);
    y  = W'(r & 63);
    c  = sel ? ((ua + 64 - ub) >= 64) : ((ua + ub) >= 64);
    z  = (y == 0);
    n  = y[W-1];
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                       input bit exec_press);
    logic [W-1:0] ey;
    logic ec, ev, ez, en;
    int held, k;
    bit found;
    model(a, b, sel, ey, ec, ev, ez, en);

    sw_data = a;
    sw_sel  = 1'($urandom);
    pulse(HOLD_MIN + int'($urandom_range(0, 17)));
    wait_state("lda_state", 2'b01, 100);
    tick(GAP);
    chk("lda_single", 32'(state_o), 32'h1);
    chk("op_a", 32'(op_a), 32'(a));

    sw_data = b;
    sw_sel  = sel;
    @(negedge clk);
    btn_load = 1'b1;
    held  = 0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      held++;
      if (held == HOLD_MIN) btn_load = 1'b0;
      if (state_o == 2'b10) found = 1;
    end
    chk("exec_enter", 32'(found), 32'h1);
    chk("op_b", 32'(op_b), 32'(b));
    chk("op_sel", 32'(op_sel), 32'(sel));
    chk("op_a_hold", 32'(op_a), 32'(a));
    sw_data = W'($urandom);
    sw_sel  = 1'($urandom);

    k = 0;
    while (!result_valid && k < 300) begin
      @(negedge clk);
      k++;
      if (held < HOLD_MIN) begin
        held++;
        if (held == HOLD_MIN) btn_load = 1'b0;
      end
      if (exec_press) begin
        if (k == XP_START) btn_load = 1'b1;
        if (k == XP_START + HOLD_MIN) btn_load = 1'b0;
      end
    end
    chk("latency", 32'(k), 32'(EXN + 1));
    chk("result", 32'(result), 32'(ey));
    chk("flag_c", 32'(flag_c), 32'(ec));
    chk("flag_v", 32'(flag_v), 32'(ev));
    chk("flag_z", 32'(flag_z), 32'(ez));
    chk("flag_n", 32'(flag_n), 32'(en));
    chk("show_state", 32'(state_o), 32'h3);
    tick(GAP + HOLD_MIN);
    chk("show_stay", 32'(state_o), 32'h3);
    chk("show_valid", 32'(result_valid), 32'h1);

    sw_data = ~a;
    pulse(HOLD_MIN);
    wait_state("back_load_a", 2'b00, 100);
    chk("valid_clr", 32'(result_valid), 32'h0);
    chk("op_a_show", 32'(op_a), 32'(a));
    tick(GAP);
  endtask

  initial begin
    // Reset with the button pulsing: nothing may be captured.
    sw_data = 6'h2a;
    sw_sel  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      btn_load = ~btn_load;
      @(negedge clk);
    end
    btn_load = 1'b0;
    chk("rst_state", 32'(state_o), 32'h0);
    chk("rst_op_a", 32'(op_a), 32'h0);
    chk("rst_op_b", 32'(op_b), 32'h0);
    chk("rst_op_sel", 32'(op_sel), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", 32'({flag_c, flag_v, flag_z, flag_n}), 32'h0);
    chk("rst_valid", 32'(result_valid), 32'h0);
    rst_n = 1'b1;
    tick(GAP + 4);
    chk("post_rst_idle", 32'(state_o), 32'h0);

    // Reset mid-operation drops the loaded A.
    sw_data = 6'h15;
    pulse(HOLD_MIN);
    wait_state("mid_lda", 2'b01, 100);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_state", 32'(state_o), 32'h0);
    chk("mid_rst_op_a", 32'(op_a), 32'h0);
    rst_n = 1'b1;
    tick(GAP);

`ifdef ALU_SEQ_DEBOUNCE_EN
    // Short glitches never make it through; a clean hold gives exactly one press.
    for (int g = 0; g < 5; g++) begin
      pulse(3);
      tick(3);
    end
    tick(DB + 4);
    chk("glitch_ignored", 32'(state_o), 32'h0);
    sw_data = 6'h09;
    pulse(DB + 6);
    tick(GAP);
    chk("db_one_press", 32'(state_o), 32'h1);
    chk("db_op_a", 32'(op_a), 32'h09);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(GAP);
`endif

    do_op(6'b101100, 6'b110001, 1'b1, 1'b0);
    do_op(6'b011111, 6'b000001, 1'b0, 1'b1);
    do_op(6'b100000, 6'b100000, 1'b0, 1'b0);
    do_op(6'b000000, 6'b000000, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'(i % 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential front end for the 6-bit add/subtract unit.
- Captures operand A, then operand B and SEL, from board switches on successive load-button presses.
- Drives the held operands into the external Sum_Rest_6bit adder, waits for it to settle, then registers its Y/Cout together with derived status flags for display.
- Acts as the initiator side of the adder's operand/result interface.

Parameters:
- WIDTH, 6: operand and result width.
- EXEC_CYCLES, 1: settle cycles held in EXEC before the result is captured (must be ≥1).
- DEBOUNCE_CYCLES, 16: stable-input cycles required by the optional debouncer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- btn_load  in  1  raw load push-button, asynchronous to clk
- sw_data  in  WIDTH  operand switches, two's complement
- sw_sel  in  1  operation select: 0 = add, 1 = subtract
- op_a  out  WIDTH  registered operand A to adder
- op_b  out  WIDTH  registered operand B to adder
- op_sel  out  1  registered SEL to adder
- alu_y  in  WIDTH  adder result
- alu_cout  in  1  adder carry out
- result  out  WIDTH  captured result
- flag_c  out  1  captured carry
- flag_v  out  1  signed overflow
- flag_z  out  1  result == 0
- flag_n  out  1  result MSB
- result_valid  out  1  high while the captured result is valid
- state_o  out  2  current state, for LEDs

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-low on rst_n; all state changes on the rising edge of clk.
- Reset (rst_n=0 at a clk edge):
  - state = LOAD_A.
  - op_a, op_b, op_sel, result and all flags = 0; result_valid = 0.
  - Synchronizer, edge detector and debounce counters cleared.
  - Reset mid-operation discards partial operands; no capture completes.
- Input conditioning:
  - btn_load passes through a 2-flop synchronizer.
  - press = synchronized rising edge, one clk pulse. A held button produces exactly one press.
  - Minimum 3-cycle latency from pin to press.
- States (encoding on state_o):
  - LOAD_A (00): on press, op_a <= sw_data, go to LOAD_B. result_valid is already 0 here.
  - LOAD_B (01): on press, op_b <= sw_data and op_sel <= sw_sel in the same edge; load settle counter; go to EXEC.
  - EXEC (10): counter runs EXEC_CYCLES cycles. On the final cycle:
    - result <= alu_y; flag_c <= alu_cout; flags computed from op_a, op_b, op_sel and alu_y.
    - result_valid <= 1; go to SHOW.
    - Presses during EXEC are ignored.
  - SHOW (11): outputs held. On press, result_valid <= 0 and go to LOAD_A. Switches are not sampled on this press.
- Operands stay stable from the edge after they are loaded until overwritten. op_a is unchanged through LOAD_B, EXEC and SHOW.
- Flags (WIDTH-bit two's complement):
  - Add: V = (a_msb == b_msb) && (y_msb != a_msb).
  - Subtract: V = (a_msb != b_msb) && (y_msb != a_msb).
  - Z = ~|alu_y; N = alu_y[WIDTH-1]; C = alu_cout taken as-is.
- Latency: result_valid rises EXEC_CYCLES+1 clk edges after the edge that registers the B press.
- Edge cases:
  - Switch changes outside the capture edges have no effect.
  - A press coincident with deasserted reset is lost, because reset has priority.

Optional Feature:
- Macro: ALU_SEQ_DEBOUNCE_EN.
- Defined: the synchronized button feeds a debouncer. Its output toggles only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles (counter clears on any bounce). press is the rising edge of the debounced level, adding DEBOUNCE_CYCLES of latency.
- Undefined: press is taken directly from the synchronized signal. Bench drives clean pulses.

Decomposition:
- Package alu_seq_pkg holds:
  - state typedef and encodings: LOAD_A=2'b00, LOAD_B=2'b01, EXEC=2'b10, SHOW=2'b11;
  - default WIDTH and DEBOUNCE_CYCLES constants.
- One sub-module: btn_conditioner. It contains the synchronizer, the optional debouncer and the edge detector, and outputs the single-cycle press.

Test Plan:
- Reset: hold rst_n=0 two cycles with btn pulsing -> state_o=00, all outputs 0, no capture occurs.
- Subtract: A=6'b101100 (-20), B=6'b110001 (-15), SEL=1 -> result=6'b111011 (-5), C=0, V=0, Z=0, N=1; result_valid rises EXEC_CYCLES+1 edges after the B-capture edge.
- Add overflow: A=6'b011111 (31), B=6'b000001, SEL=0 -> result=6'b100000, V=1, N=1, C=0.
- Zero/carry: A=6'b100000, B=6'b100000, SEL=0 -> result=0, Z=1, C=1, V=1.
- Robustness:
  - Button held 20 cycles in LOAD_A -> single capture, state 01.
  - Press during EXEC -> ignored.
  - Press in SHOW -> result_valid=0, state 00, op_a unchanged.
- With ALU_SEQ_DEBOUNCE_EN: 3-cycle glitches -> no press; clean hold ≥ DEBOUNCE_CYCLES+3 -> exactly one press.
